vga_text_console: RTL and testbench

- Character-stream console controller that owns the CPU-side port of the 80x30 text frame buffer (4096 x 16-bit dual-port RAM).
- Accepts bytes over a valid/ready handshake and writes glyph cells at a hardware cursor.
- Interprets control codes: newline, carriage return, backspace, clear and attribute set.
- Sequences full-screen clear and one-row scroll by driving read/modify/write cycles on the RAM port.

---
 rtl/vga_console_pkg.sv | 25 ++
 rtl/vga_console_addr.sv | 15 +
 rtl/vga_text_console.sv | 209 ++++++++++++++++++++
 tb/tb_vga_text_console.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_console_pkg.sv
// Shared types and constants for the VGA text console controller.
// Optional one-row scroll is enabled by defining VGA_CONSOLE_SCROLL_EN.
package vga_console_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PUT,
        ST_CLEAR,
        ST_SCR_RD,
        ST_SCR_WR,
        ST_SCR_CLR
    } state_t;

    localparam logic [7:0] CC_LF  = 8'h0A;
    localparam logic [7:0] CC_CR  = 8'h0D;
    localparam logic [7:0] CC_BS  = 8'h08;
    localparam logic [7:0] CC_FF  = 8'h0C;
    localparam logic [7:0] CC_ESC = 8'h1B;
    localparam logic [7:0] SPACE  = 8'h20;

    function automatic logic [15:0] pack_cell(input logic [7:0] attr, input logic [7:0] ch);
        return {attr, ch};
    endfunction

endpackage

// File: rtl/vga_console_addr.sv
// Frame-buffer address of a cursor position: row*80 + col built from shifts,
// so no multiplier is inferred.
module vga_console_addr #(
    parameter int ADDR_W = 12
) (
    input  logic [4:0]        row,
    input  logic [6:0]        col,
    output logic [ADDR_W-1:0] addr
);

    always_comb begin
        addr = (ADDR_W'(row) << 6) + (ADDR_W'(row) << 4) + ADDR_W'(col);
    end

endmodule

// File: rtl/vga_text_console.sv
// Character-stream console: writes glyphs at a cursor, handles control codes,
// and sequences screen clear / row scroll. Define VGA_CONSOLE_SCROLL_EN to scroll
// on the last row; otherwise the cursor wraps to row 0 and that row is blanked.
module vga_text_console
    import vga_console_pkg::*;
#(
    parameter int          COLS         = 80,
    parameter int          ROWS         = 30,
    parameter int          ADDR_W       = 12,
    parameter logic [7:0]  DEFAULT_ATTR = 8'h0F
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_char,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wd,
    input  logic [15:0]       mem_rd,
    output logic [6:0]        cursor_col,
    output logic [4:0]        cursor_row,
    output logic              busy
);

    localparam logic [6:0]        LAST_COL  = 7'(COLS - 1);
    localparam logic [4:0]        LAST_ROW  = 5'(ROWS - 1);
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
`ifdef VGA_CONSOLE_SCROLL_EN
    localparam logic [ADDR_W-1:0] COLS_A        = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] LAST_ROW_BASE = ADDR_W'(COLS * (ROWS - 1));
    localparam logic [ADDR_W-1:0] SCR_CLR_END   = LAST_CELL;
`else
    localparam logic [ADDR_W-1:0] SCR_CLR_END   = ADDR_W'(COLS - 1);
`endif

    state_t            state;
    state_t            adv_state;
    logic [6:0]        col;
    logic [4:0]        row;
    logic [4:0]        adv_row;
    logic [7:0]        attr;
    logic [7:0]        ch;
    logic              esc_pending;
    logic [ADDR_W-1:0] clr_addr;
    logic [ADDR_W-1:0] cur_addr;
`ifdef VGA_CONSOLE_SCROLL_EN
    logic [ADDR_W-1:0] src;
`else
    logic              unused_rd;
    assign unused_rd = ^mem_rd;
`endif

    vga_console_addr #(.ADDR_W(ADDR_W)) u_addr (
        .row  (row),
        .col  (col),
        .addr (cur_addr)
    );

    // Outcome of a row advance, shared by line feed and end-of-row wrap.
    always_comb begin
        adv_row   = row + 5'd1;
        adv_state = ST_IDLE;
        if (row == LAST_ROW) begin
`ifdef VGA_CONSOLE_SCROLL_EN
            adv_row   = row;
            adv_state = ST_SCR_RD;
`else
            adv_row   = '0;
            adv_state = ST_SCR_CLR;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_CLEAR;
            clr_addr    <= '0;
            col         <= '0;
            row         <= '0;
            attr        <= DEFAULT_ATTR;
            ch          <= '0;
            esc_pending <= 1'b0;
`ifdef VGA_CONSOLE_SCROLL_EN
            src         <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (esc_pending) begin
                            attr        <= in_char;
                            esc_pending <= 1'b0;
                        end else begin
                            case (in_char)
                                CC_ESC: esc_pending <= 1'b1;
                                CC_CR:  col <= '0;
                                CC_BS:  if (col != '0) col <= col - 7'd1;
                                CC_LF: begin
                                    col   <= '0;
                                    row   <= adv_row;
                                    state <= adv_state;
`ifdef VGA_CONSOLE_SCROLL_EN
                                    src   <= COLS_A;
`else
                                    clr_addr <= '0;
`endif
                                end
                                CC_FF: begin
                                    col      <= '0;
                                    row      <= '0;
                                    clr_addr <= '0;
                                    state    <= ST_CLEAR;
                                end
                                default: begin
                                    ch    <= in_char;
                                    state <= ST_PUT;
                                end
                            endcase
                        end
                    end
                end
                ST_PUT: begin
                    if (col == LAST_COL) begin
                        col   <= '0;
                        row   <= adv_row;
                        state <= adv_state;
`ifdef VGA_CONSOLE_SCROLL_EN
                        src   <= COLS_A;
`else
                        clr_addr <= '0;
`endif
                    end else begin
                        col   <= col + 7'd1;
                        state <= ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    if (clr_addr == LAST_CELL) state <= ST_IDLE;
                    else                       clr_addr <= clr_addr + ONE;
                end
`ifdef VGA_CONSOLE_SCROLL_EN
                ST_SCR_RD: state <= ST_SCR_WR;
                ST_SCR_WR: begin
                    src <= src + ONE;
                    if (src == LAST_CELL) begin
                        clr_addr <= LAST_ROW_BASE;
                        state    <= ST_SCR_CLR;
                    end else begin
                        state <= ST_SCR_RD;
                    end
                end
`endif
                ST_SCR_CLR: begin
                    if (clr_addr == SCR_CLR_END) state <= ST_IDLE;
                    else                         clr_addr <= clr_addr + ONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: RAM controls are decoded from state rather than registered so that
    // an asserted rst silences the port in the same cycle; every output gets a
    // default first so no latch can be inferred.
    always_comb begin
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_wd   = '0;
        if (!rst) begin
            case (state)
                ST_PUT: begin
                    mem_en   = 1'b1;
                    mem_we   = 1'b1;
                    mem_addr = cur_addr;
                    mem_wd   = pack_cell(attr, ch);
                end
                ST_CLEAR, ST_SCR_CLR: begin
                    mem_en   = 1'b1;
                    mem_we   = 1'b1;
                    mem_addr = clr_addr;
                    mem_wd   = pack_cell(attr, SPACE);
                end
`ifdef VGA_CONSOLE_SCROLL_EN
                ST_SCR_RD: begin
                    mem_en   = 1'b1;
                    mem_addr = src;
                end
                ST_SCR_WR: begin
                    mem_en   = 1'b1;
                    mem_we   = 1'b1;
                    mem_addr = src - COLS_A;
                    mem_wd   = mem_rd;
                end
`endif
                default: ;
            endcase
        end
    end

    assign in_ready   = (state == ST_IDLE) && !rst;
    assign busy       = rst || !((state == ST_IDLE) || (state == ST_PUT));
    assign cursor_col = col;
    assign cursor_row = row;

endmodule

// File: tb/tb_vga_text_console.sv
// Randomized self-checking bench for vga_text_console with a screen-level
// reference model; follows VGA_CONSOLE_SCROLL_EN the same way as the design.
module tb_vga_text_console;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_char;
    logic        mem_en;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [15:0] mem_wd;
    logic [15:0] mem_rd;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;

    always #5 clk = ~clk;

    vga_text_console dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_char    (in_char),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    // Frame-buffer RAM with one-cycle read latency, plus a log of every write.
    logic [15:0] ram [0:4095];
    logic [11:0] wa_q [$];
    logic [15:0] wd_q [$];
    int          busy_cnt;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr] <= mem_wd;
                wa_q.push_back(mem_addr);
                wd_q.push_back(mem_wd);
            end
            mem_rd <= ram[mem_addr];
        end
    end

    always @(negedge clk) if (busy) busy_cnt++;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: the screen as the console user sees it.
    logic [15:0] exp_scr [0:2399];
    logic [15:0] snap    [0:2399];
    int          e_row, e_col;
    logic [7:0]  e_attr;
    bit          e_esc;

    function automatic void m_fill(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) exp_scr[i] = {e_attr, 8'h20};
    endfunction

    function automatic void m_reset();
        e_row = 0; e_col = 0; e_attr = 8'h0F; e_esc = 1'b0;
        m_fill(0, 2399);
    endfunction

    function automatic void m_advance();
        if (e_row < 29) begin
            e_row++;
        end else begin
`ifdef VGA_CONSOLE_SCROLL_EN
            for (int i = 0; i < 2320; i++) exp_scr[i] = exp_scr[i + 80];
            m_fill(2320, 2399);
`else
            e_row = 0;
            m_fill(0, 79);
`endif
        end
    endfunction

    function automatic void m_byte(input logic [7:0] b);
        if (e_esc) begin
            e_attr = b;
            e_esc  = 1'b0;
            return;
        end
        case (b)
            8'h1B: e_esc = 1'b1;
            8'h0D: e_col = 0;
            8'h08: if (e_col > 0) e_col--;
            8'h0A: begin e_col = 0; m_advance(); end
            8'h0C: begin e_col = 0; e_row = 0; m_fill(0, 2399); end
            default: begin
                exp_scr[e_row * 80 + e_col] = {e_attr, b};
                if (e_col == 79) begin e_col = 0; m_advance(); end
                else e_col++;
            end
        endcase
    endfunction

    task automatic wait_ready(input int budget);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("ready_timeout", {31'b0, in_ready}, 32'd1);
    endtask

    task automatic send_m(input logic [7:0] b);
        wait_ready(6000);
        in_valid = 1'b1;
        in_char  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_char  = 8'($urandom);
        m_byte(b);
    endtask

    task automatic check_cursor(input string tag);
        check({tag, "_col"}, 32'(cursor_col), 32'(e_col));
        check({tag, "_row"}, 32'(cursor_row), 32'(e_row));
    endtask

    task automatic check_screen(input string tag);
        int bad = 0;
        for (int i = 0; i < 2400; i++) if (ram[i] !== exp_scr[i]) bad++;
        check(tag, bad, 0);
    endtask

    // Logged writes [offset, offset+n) must hit first_addr.. consecutively with data.
    task automatic check_log(input string tag, input int first_addr, input int n,
                             input logic [15:0] data, input int offset);
        int bad = 0;
        for (int k = 0; k < n; k++) begin
            if (offset + k >= wa_q.size()) bad++;
            else if (wa_q[offset + k] !== 12'(first_addr + k) || wd_q[offset + k] !== data) bad++;
        end
        check(tag, bad, 0);
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        busy_cnt = 0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_char  = 8'h00;
        for (int i = 0; i < 4096; i++) ram[i] = 16'($urandom);

        // Reset and power-on clear.
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_mem_en", {31'b0, mem_en}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd1);
        check("rst_ready", {31'b0, in_ready}, 32'd0);
        clear_log();
        rst = 1'b0;
        m_reset();
        wait_ready(3000);
        check("clr_busy_cycles", busy_cnt, 2400);
        check("clr_count", wa_q.size(), 2400);
        check_log("clr_seq", 0, 2400, 16'h0F20, 0);
        check_cursor("clr");
        check_screen("clr_screen");

        // Single glyph: one write, ready comes back after the PUT cycle.
        clear_log();
        send_m(8'h41);
        @(negedge clk);
        check("put_ready_low", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        check("put_ready_back", {31'b0, in_ready}, 32'd1);
        check("A_count", wa_q.size(), 1);
        check_log("A_write", 0, 1, 16'h0F41, 0);
        check_cursor("A");

        // Attribute escape followed by a glyph.
        clear_log();
        send_m(8'h1B);
        send_m(8'h1E);
        send_m(8'h42);
        wait_ready(100);
        check("esc_count", wa_q.size(), 1);
        check_log("esc_write", 1, 1, 16'h1E42, 0);
        check_cursor("esc");

        // Backspace down to column 0 and once more at the left edge.
        clear_log();
        for (int i = 0; i < 3; i++) begin
            send_m(8'h08);
            wait_ready(100);
            check_cursor("bs");
        end
        check("bs_no_write", wa_q.size(), 0);

        // Random byte stream, cursor compared after every byte.
        for (int i = 0; i < 150; i++) begin
            int r;
            logic [7:0] b;
            r = $urandom_range(0, 99);
            if      (r < 8)  b = 8'h0A;
            else if (r < 12) b = 8'h0D;
            else if (r < 16) b = 8'h08;
            else if (r < 19) b = 8'h1B;
            else if (r < 20) b = 8'h0C;
            else             b = 8'($urandom_range(32, 126));
            send_m(b);
            wait_ready(6000);
            check_cursor("rand");
        end
        check_screen("rand_screen");

        // Known attribute, clear, then move to the bottom-right cell.
        if (e_esc) send_m(8'h0F);
        send_m(8'h1B);
        send_m(8'h0F);
        send_m(8'h0C);
        for (int i = 0; i < 29; i++) send_m(8'h0A);
        for (int i = 0; i < 79; i++) send_m(8'($urandom_range(33, 126)));
        wait_ready(100);
        check_cursor("pre_edge");
        for (int i = 0; i < 2400; i++) snap[i] = ram[i];

        // Glyph at 29,79 forces a row advance past the last row.
        clear_log();
        send_m(8'h5A);
        wait_ready(6000);
        check_log("edge_put", 2399, 1, 16'h0F5A, 0);
`ifdef VGA_CONSOLE_SCROLL_EN
        begin
            int bad = 0;
            for (int k = 0; k < 2320; k++) begin
                logic [15:0] want;
                want = (k + 80 == 2399) ? 16'h0F5A : snap[k + 80];
                if (1 + k >= wa_q.size()) bad++;
                else if (wa_q[1 + k] !== 12'(k) || wd_q[1 + k] !== want) bad++;
            end
            check("scroll_copy", bad, 0);
        end
        check_log("scroll_blank", 2320, 80, 16'h0F20, 2321);
        check("scroll_busy", busy_cnt, 4720);
        check("scroll_count", wa_q.size(), 2401);
`else
        check_log("wrap_blank", 0, 80, 16'h0F20, 1);
        check("wrap_busy", busy_cnt, 80);
        check("wrap_count", wa_q.size(), 81);
`endif
        check_cursor("edge");
        check_screen("edge_screen");

        // Line feed on the last row.
        while (e_row < 29) send_m(8'h0A);
        wait_ready(6000);
        clear_log();
        send_m(8'h0A);
        wait_ready(6000);
`ifdef VGA_CONSOLE_SCROLL_EN
        check("lf_busy", busy_cnt, 4720);
        check("lf_count", wa_q.size(), 2400);
`else
        check("lf_busy", busy_cnt, 80);
        check("lf_count", wa_q.size(), 80);
        check_log("lf_blank", 0, 80, 16'h0F20, 0);
`endif
        check_cursor("lf");
        check_screen("lf_screen");

        // Reset in the middle of the scroll / wrap blanking.
        while (e_row < 29) send_m(8'h0A);
        send_m(8'h0A);
        repeat (20) @(negedge clk);
        check("mid_busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_we", {31'b0, mem_we}, 32'd0);
        check("mid_rst_en", {31'b0, mem_en}, 32'd0);
        @(posedge clk);
        #1;
        check("mid_rst_col", 32'(cursor_col), 32'd0);
        check("mid_rst_row", 32'(cursor_row), 32'd0);
        clear_log();
        rst = 1'b0;
        m_reset();
        wait_ready(3000);
        check("reclr_busy", busy_cnt, 2400);
        check_log("reclr_seq", 0, 2400, 16'h0F20, 0);
        check_screen("reclr_screen");

        // Attribute is back to default after reset.
        clear_log();
        send_m(8'h6B);
        wait_ready(100);
        check_log("post_rst_put", 0, 1, 16'h0F6B, 0);
        check_cursor("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
